// File: rtl/dmem_mmio_port.sv
// MMIO responder on the data-memory bus: cycle counter, result FIFO, status and halt registers.
// Optional `MMIO_CYCLE_COUNTER_EN` builds the free-running CYCLE counter; otherwise CYCLE reads 0.
module dmem_mmio_port #(
    parameter logic [0:31] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:31] addr,
    input  logic [0:31] wData,
    input  logic        writeEnable,
    input  logic [0:1]  dsize,
    output logic [0:31] rData,
    output logic        hit,
    output logic [0:31] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        halted
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [0:31]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_size_err;
    logic          r_halted;

    logic [1:0]    w_off;
    logic          w_wr;
    logic          w_word;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic [0:31]   w_cycle;
    logic [0:31]   w_status;
    logic          w_unused_addr;

    assign hit           = (addr[0:27] == BASE_ADDR[0:27]);
    assign w_off         = addr[28:29];
    assign w_unused_addr = &{1'b0, addr[30:31]};
    assign w_wr          = writeEnable & hit;
    assign w_word        = (dsize == 2'b00);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_push        = w_wr & w_word & (w_off == 2'd1);
    assign w_pop         = ~w_empty & out_ready;
    // A push into a full FIFO only lands if the head leaves on the same edge.
    assign w_push_ok     = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_size_err <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_push & w_full & ~w_pop)
                r_overflow <= 1'b1;
            else if (w_wr & w_word & (w_off == 2'd2))
                r_overflow <= 1'b0;

            // Any non-word hit is dropped and flagged, whatever register it targets.
            if (w_wr & ~w_word)
                r_size_err <= 1'b1;
            else if (w_wr & (w_off == 2'd2))
                r_size_err <= 1'b0;

            if (w_wr & w_word & (w_off == 2'd3))
                r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= wData;
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cycle <= '0;
        else      r_cycle <= r_cycle + 32'd1;
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    always_comb begin
        w_status        = '0;
        w_status[8:15]  = 8'(r_count);
        w_status[27]    = r_halted;
        w_status[28]    = r_size_err;
        w_status[29]    = r_overflow;
        w_status[30]    = w_full;
        w_status[31]    = w_empty;

        rData = '0;
        if (hit) begin
            case (w_off)
                2'd0:    rData = w_cycle;
                2'd2:    rData = w_status;
                default: rData = '0;
            endcase
        end
    end

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rptr];
    assign halted    = r_halted;

endmodule

// File: tb/tb_dmem_mmio_port.sv
// Directed bench for dmem_mmio_port; FIFO output words are checked by a scoreboard monitor.
module tb_dmem_mmio_port;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [1:0]  SZ_W = 2'b00;
    localparam logic [1:0]  SZ_B = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wData = '0;
    logic        writeEnable = 1'b0;
    logic [1:0]  dsize = 2'b00;
    logic [31:0] rData;
    logic        hit;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb [$];

    dmem_mmio_port #(.BASE_ADDR(32'hFFFF_0000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wData(wData),
        .writeEnable(writeEnable), .dsize(dsize), .rData(rData), .hit(hit),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; the write lands on the next edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        addr = a; wData = d; dsize = sz; writeEnable = 1'b1;
        @(posedge clk); #1;
        writeEnable = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; #1;
        chk(name, rData, exp);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_pop: got %08h expected none", out_data);
            end else begin
                chk("fifo_word", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cycle;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
`ifdef MMIO_CYCLE_COUNTER_EN
        exp_cycle = 32'd5;
`else
        exp_cycle = 32'd0;
`endif
        rd("cycle_5", BASE + 32'h0, exp_cycle);
        rd("status_idle", BASE + 32'h8, 32'h0000_0001);
        chk("hit_in_window", {31'd0, hit}, 32'd1);

        // Push then drain two words
        wr(BASE + 32'h4, 32'hDEAD_BEEF, SZ_W); sb.push_back(32'hDEAD_BEEF);
        wr(BASE + 32'h4, 32'h1234_5678, SZ_W); sb.push_back(32'h1234_5678);
        rd("status_two", BASE + 32'h8, 32'h0002_0000);
        chk("valid_two", {31'd0, out_valid}, 32'd1);
        chk("head_two", out_data, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("valid_drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Overflow: nine pushes into depth 8
        for (int i = 1; i <= 9; i++) begin
            wr(BASE + 32'h4, 32'(i), SZ_W);
            if (i <= 8) sb.push_back(32'(i));
        end
        rd("status_ovf", BASE + 32'h8, 32'h0008_0006);
        wr(BASE + 32'h8, 32'h0, SZ_W);
        rd("status_ovf_clr", BASE + 32'h8, 32'h0008_0002);

        // Full with simultaneous push and pop
        out_ready = 1'b1;
        wr(BASE + 32'h4, 32'hA5A5_A5A5, SZ_W); sb.push_back(32'hA5A5_A5A5);
        out_ready = 1'b0;
        rd("status_full_pp", BASE + 32'h8, 32'h0008_0002);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("valid_after_drain", {31'd0, out_valid}, 32'd0);
        chk("sb_empty_drain", 32'(sb.size()), 32'd0);
        out_ready = 1'b0;
        rd("status_empty", BASE + 32'h8, 32'h0000_0001);

        // Size error and decode miss
        wr(BASE + 32'h4, 32'h0000_CAFE, SZ_B);
        rd("status_size_err", BASE + 32'h8, 32'h0000_0009);
        wr(BASE + 32'h10, 32'h0000_0077, SZ_W);
        addr = BASE + 32'h10; #1;
        chk("hit_outside", {31'd0, hit}, 32'd0);
        chk("rdata_outside", rData, 32'd0);
        chk("valid_no_push", {31'd0, out_valid}, 32'd0);
        rd("status_after_miss", BASE + 32'h8, 32'h0000_0009);
        wr(BASE + 32'h8, 32'h0000_0123, SZ_W);
        rd("status_err_clr", BASE + 32'h8, 32'h0000_0001);

        // Halt is sticky and does not block the FIFO
        wr(BASE + 32'hC, 32'h0, SZ_W);
        chk("halted_set", {31'd0, halted}, 32'd1);
        rd("status_halted", BASE + 32'h8, 32'h0000_0011);
        rd("halt_reads_zero", BASE + 32'hC, 32'h0);
        wr(BASE + 32'h4, 32'hBEEF_0001, SZ_W); sb.push_back(32'hBEEF_0001);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("halted_sticky", {31'd0, halted}, 32'd1);
        chk("sb_empty_halt", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-operation, no clock edge in between
        wr(BASE + 32'h4, 32'h0000_0055, SZ_W);
        chk("valid_before_rst", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b0;
        #2;
        chk("rst_async_halted", {31'd0, halted}, 32'd0);
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_data", out_data, 32'd0);
        rd("rst_async_status", BASE + 32'h8, 32'h0000_0001);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("valid_after_rst", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
